// File: rtl/apb_master_pkg.sv
// Shared types and sizing helpers for the APB command master.
// The state encoding is 2 bits; helper functions derive strobe and counter widths.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int BYTE_OFFSET_W = 2;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_cmd_master.sv
// APB4 master: one SETUP/ACCESS transfer per accepted command, response on a
// valid/ready port, and a PREADY watchdog so a hung slave cannot lock the bus.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                                pclk_i,
  input  logic                                prst_n_i,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic                                cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]               cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]               cmd_wdata_i,
  input  logic [strb_width(DATA_WIDTH)-1:0]   cmd_strb_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
  output logic                                rsp_err_o,
  output logic                                psel_o,
  output logic                                penable_o,
  output logic                                pwrite_o,
  output logic [ADDR_WIDTH+BYTE_OFFSET_W-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0]               pwdata_o,
  output logic [strb_width(DATA_WIDTH)-1:0]   pstrb_o,
  input  logic                                pready_i,
  input  logic                                pslverr_i,
  input  logic [DATA_WIDTH-1:0]               prdata_i
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int CNT_W  = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t state, state_next;

  logic                                ready;
  logic                                accept;
  logic                                complete;
  logic                                expire;
  logic                                timeout_hit;
  logic                                apb_sel;
  logic                                apb_enable;
  logic                                resp_valid;
  logic [CNT_W-1:0]                    wait_cnt;
  logic [ADDR_WIDTH+BYTE_OFFSET_W-1:0] bus_addr;
  logic                                bus_write;
  logic [DATA_WIDTH-1:0]               bus_wdata;
  logic [STRB_W-1:0]                   bus_strb;
  logic [DATA_WIDTH-1:0]               resp_data;
  logic                                resp_error;

  assign accept      = ready && cmd_valid_i;
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);
  // pready_i has priority over an expiring watchdog in the same cycle.
  assign complete    = (state == ACCESS) && pready_i;
  assign expire      = (state == ACCESS) && !pready_i && timeout_hit;

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    apb_sel    = 1'b0;
    apb_enable = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        apb_sel    = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        apb_sel    = 1'b1;
        apb_enable = 1'b1;
        if (complete || expire) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered so that cmd_ready_o is low while reset is held.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      ready <= 1'b0;
    end else begin
      ready <= (state_next == IDLE);
    end
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready_i) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      bus_addr  <= '0;
      bus_write <= 1'b0;
      bus_wdata <= '0;
      bus_strb  <= '0;
    end else if (accept) begin
      bus_addr  <= {cmd_addr_i, {BYTE_OFFSET_W{1'b0}}};
      bus_write <= cmd_write_i;
      bus_wdata <= cmd_write_i ? cmd_wdata_i : '0;
      bus_strb  <= cmd_write_i ? cmd_strb_i : '0;
    end
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else if (complete) begin
      resp_data  <= bus_write ? '0 : prdata_i;
      resp_error <= pslverr_i;
    end else if (expire) begin
      resp_data  <= '0;
      resp_error <= 1'b1;
    end
  end

  assign cmd_ready_o = ready;
  assign rsp_valid_o = resp_valid;
  assign rsp_rdata_o = resp_data;
  assign rsp_err_o   = resp_error;
  assign psel_o      = apb_sel;
  assign penable_o   = apb_enable;
  assign pwrite_o    = bus_write;
  assign paddr_o     = bus_addr;
  assign pwdata_o    = bus_wdata;
  assign pstrb_o     = bus_strb;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: a transaction-level model predicts
// APB phases, latency and responses; a bench-side word memory acts as the slave.
module tb_apb_cmd_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          prst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW+1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;

  apb_cmd_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .pclk_i(pclk),
    .prst_n_i(prst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .psel_o(psel),
    .penable_o(penable),
    .pwrite_o(pwrite),
    .paddr_o(paddr),
    .pwdata_o(pwdata),
    .pstrb_o(pstrb),
    .pready_i(pready),
    .pslverr_i(pslverr),
    .prdata_i(prdata)
  );

  initial forever #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int vectors = 0;
  int miscompares = 0;

  // Expected transaction, described only by what the command asked for.
  bit            m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_strb;
  int            m_len;
  logic [DW-1:0] m_rdata;
  bit            m_err;
  logic [DW-1:0] model_mem [0:1023];

  int            s_waits = 0;
  bit            s_err = 1'b0;
  logic [DW-1:0] s_errdata = '0;

  bit            busy = 1'b0;
  int            acc_cyc = 0;
  int            cyc = 0;
  int            skip = 2;

  int            lat;
  logic [AW+1:0] setup_paddr;
  logic [DW-1:0] got_rdata;
  logic          got_err;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare_cycle();
    int rel;
    bit e_psel, e_pen, e_rv;
    cyc++;
    if (!prst_n) begin
      busy = 1'b0;
      skip = 2;
      return;
    end
    rel    = cyc - acc_cyc;
    e_psel = busy && (rel >= 1) && (rel <= 1 + m_len);
    e_pen  = busy && (rel >= 2) && (rel <= 1 + m_len);
    e_rv   = busy && (rel >= 2 + m_len);
    if (skip > 0) skip--;
    else check_output("cmd_ready", cmd_ready, !busy);
    check_output("psel", psel, e_psel);
    check_output("penable", penable, e_pen);
    if (e_psel) begin
      check_output("paddr", paddr, 64'(m_addr) * 64'd4);
      check_output("pwrite", pwrite, m_write);
      check_output("pwdata", pwdata, m_write ? m_wdata : 32'h0);
      check_output("pstrb", pstrb, m_write ? m_strb : 4'h0);
    end
    check_output("rsp_valid", rsp_valid, e_rv);
    if (e_rv) begin
      check_output("rsp_rdata", rsp_rdata, m_rdata);
      check_output("rsp_err", rsp_err, m_err);
    end
    if (busy && rsp_valid && rsp_ready) busy = 1'b0;
    else if (!busy && cmd_valid && cmd_ready) begin
      busy    = 1'b1;
      acc_cyc = cyc;
    end
  endtask

  // Slave: inserts s_waits low-PREADY cycles, then completes from its own memory.
  initial begin
    int acc_seen;
    int wi;
    logic [DW-1:0] slave_mem [0:1023];
    acc_seen = 0;
    for (int i = 0; i < 1024; i++) slave_mem[i] = '0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (acc_seen >= s_waits) begin
          pready  = 1'b1;
          pslverr = s_err;
          wi      = int'(paddr[AW+1:2]);
          if (pwrite) begin
            for (int b = 0; b < SW; b++)
              if (pstrb[b]) slave_mem[wi][8*b +: 8] = pwdata[8*b +: 8];
            prdata = 32'h0;
          end else begin
            prdata = s_err ? s_errdata : slave_mem[wi];
          end
        end else begin
          pready  = 1'b0;
          pslverr = 1'b0;
          prdata  = 32'hBAD0_BAD0;
        end
        acc_seen++;
      end else begin
        pready   = 1'b0;
        pslverr  = 1'b0;
        prdata   = 32'h0;
        acc_seen = 0;
      end
    end
  end

  task automatic set_model(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb, input int waits, input bit serr,
                           input logic [DW-1:0] edata);
    bit timed;
    timed   = (TO != 0) && (waits >= TO);
    m_write = wr;
    m_addr  = addr;
    m_wdata = wdata;
    m_strb  = strb;
    m_len   = timed ? TO : waits + 1;
    if (timed) begin
      m_rdata = 32'h0;
      m_err   = 1'b1;
    end else if (wr) begin
      m_rdata = 32'h0;
      m_err   = serr;
      for (int b = 0; b < SW; b++)
        if (strb[b]) model_mem[addr][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      m_rdata = serr ? edata : model_mem[addr];
      m_err   = serr;
    end
    s_waits   = waits;
    s_err     = serr;
    s_errdata = edata;
  endtask

  task automatic drive_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb);
    @(posedge pclk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = ~addr;
    cmd_wdata = ~wdata;
    cmd_strb  = ~strb;
  endtask

  task automatic apply_stimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic [SW-1:0] strb, input int waits, input bit serr,
                                input logic [DW-1:0] edata, input int delay);
    bit got;
    set_model(wr, addr, wdata, strb, waits, serr, edata);
    drive_cmd(wr, addr, wdata, strb);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge pclk);
      lat++;
      if (lat == 1) setup_paddr = paddr;
      if (rsp_valid) got = 1'b1;
    end
    if (!got) check_output("rsp_arrival", 64'd0, 64'd1);
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    repeat (delay) @(negedge pclk);
    @(posedge pclk); #1;
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    fork
      forever begin
        @(negedge pclk);
        compare_cycle();
      end
    join_none

    #12;
    check_output("reset_psel", psel, 0);
    check_output("reset_penable", penable, 0);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_cmd_ready", cmd_ready, 0);
    check_output("reset_paddr", paddr, 0);
    @(posedge pclk); #1;
    prst_n = 1'b1;
    repeat (3) @(negedge pclk);
    check_output("post_reset_ready", cmd_ready, 1);

    apply_stimulus(1'b1, 10'h005, 32'hA5A5_1234, 4'hF, 0, 1'b0, 32'h0, 0);
    check_output("wr_paddr_lit", setup_paddr, 12'h014);
    check_output("wr_latency", lat, 3);
    check_output("wr_err_lit", got_err, 0);
    check_output("wr_rdata_lit", got_rdata, 0);

    apply_stimulus(1'b0, 10'h005, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0, 0);
    check_output("rd_paddr_lit", setup_paddr, 12'h014);
    check_output("rd_latency", lat, 3);
    check_output("rd_rdata_lit", got_rdata, 32'hA5A5_1234);
    check_output("rd_err_lit", got_err, 0);

    apply_stimulus(1'b1, 10'h3FF, 32'h1122_3344, 4'b0101, 2, 1'b0, 32'h0, 0);
    check_output("wr2_latency", lat, 5);
    apply_stimulus(1'b0, 10'h3FF, 32'h0BAD_0BAD, 4'hF, 0, 1'b0, 32'h0, 0);
    check_output("strb_merge_lit", got_rdata, 32'h0022_0044);

    apply_stimulus(1'b0, 10'h005, 32'h0, 4'h0, 3, 1'b0, 32'h0, 0);
    check_output("wait3_latency", lat, 6);
    check_output("wait3_rdata_lit", got_rdata, 32'hA5A5_1234);
    check_output("wait3_err_lit", got_err, 0);

    apply_stimulus(1'b0, 10'h005, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF, 0);
    check_output("slverr_err_lit", got_err, 1);
    check_output("slverr_rdata_lit", got_rdata, 32'hDEAD_BEEF);

    apply_stimulus(1'b0, 10'h3FF, 32'h0, 4'h0, 100, 1'b0, 32'h0, 0);
    check_output("timeout_latency", lat, 6);
    check_output("timeout_err_lit", got_err, 1);
    check_output("timeout_rdata_lit", got_rdata, 0);
    check_output("timeout_psel_resp", psel, 0);

    apply_stimulus(1'b0, 10'h3FF, 32'hCAFE_F00D, 4'hF, 1, 1'b0, 32'h0, 5);
    check_output("bp_latency", lat, 4);
    check_output("bp_rdata_lit", got_rdata, 32'h0022_0044);

    apply_stimulus(1'b1, 10'h005, 32'h0000_00EE, 4'b0001, 0, 1'b0, 32'h0, 0);
    apply_stimulus(1'b0, 10'h005, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0);
    check_output("partial_wr_lit", got_rdata, 32'hA5A5_12EE);

    // Reset in the middle of a stalled read: everything drops, nothing is answered.
    set_model(1'b0, 10'h005, 32'h0, 4'h0, 3, 1'b0, 32'h0);
    drive_cmd(1'b0, 10'h005, 32'h0, 4'h0);
    @(negedge pclk);
    @(negedge pclk);
    check_output("pre_rst_psel", psel, 1);
    check_output("pre_rst_penable", penable, 1);
    #2;
    prst_n = 1'b0;
    #1;
    check_output("rst_psel", psel, 0);
    check_output("rst_penable", penable, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_cmd_ready", cmd_ready, 0);
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    prst_n = 1'b1;
    repeat (3) @(negedge pclk);
    check_output("rst_release_ready", cmd_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      check_output("no_spurious_rsp", rsp_valid, 0);
    end

    apply_stimulus(1'b0, 10'h005, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0);
    check_output("after_rst_latency", lat, 3);
    check_output("after_rst_rdata_lit", got_rdata, 32'hA5A5_12EE);

    repeat (4) @(negedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
